tomasulo_rs: RTL

// - Reservation station for one functional unit (arith_0/1, logic_0/1, mpy instances).
// - Accepts a registered dispatch from the dispatcher and holds up to N waiting ops.
// - Snoops the CDB to capture missing operands, then issues the oldest ready op to the FU.
// - Returns full_r to the dispatcher as backpressure.

---
 rtl/tomasulo_rs.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/tomasulo_rs.sv
// Reservation station for one functional unit: collapsing age queue with CDB snooping and a
// single-entry issue register. Optional flush port is enabled by defining TOMASULO_RS_FLUSH_EN.

module tomasulo_rs_chk #(
    parameter int N     = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             dis_vld_r,
    input logic [CNT_W-1:0] occ
);

    // A dispatch must never arrive while every slot is occupied.
    assert property (@(posedge clk) disable iff (rst) !(dis_vld_r && occ == CNT_W'(N)))
        else $error("dispatch into a full reservation station");

endmodule

module tomasulo_rs #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int TAG_W = 4,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef TOMASULO_RS_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             dis_vld_r,
    input  logic [OP_W-1:0]  dis_op,
    input  logic [TAG_W-1:0] dis_tag,
    input  logic             dis_s0_rdy,
    input  logic [TAG_W-1:0] dis_s0_tag,
    input  logic [W-1:0]     dis_s0_data,
    input  logic             dis_s1_rdy,
    input  logic [TAG_W-1:0] dis_s1_tag,
    input  logic [W-1:0]     dis_s1_data,
    output logic             full_r,
    input  logic             cdb_vld,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [W-1:0]     cdb_data,
    output logic             iss_vld_r,
    input  logic             iss_rdy,
    output logic [OP_W-1:0]  iss_op,
    output logic [TAG_W-1:0] iss_tag,
    output logic [W-1:0]     iss_a,
    output logic [W-1:0]     iss_b
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int IDX_W = $clog2(N);

    typedef struct packed {
        logic             rdy;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     data;
    } src_t;

    typedef struct packed {
        logic             vld;
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
        src_t             s0;
        src_t             s1;
    } ent_t;

    function automatic src_t snoop_src(input src_t src, input logic hit_vld,
                                       input logic [TAG_W-1:0] hit_tag,
                                       input logic [W-1:0] hit_data);
        src_t res;
        res = src;
        if (!src.rdy && hit_vld && hit_tag == src.tag) begin
            res.rdy  = 1'b1;
            res.data = hit_data;
        end else begin
            res = src;
        end
        return res;
    endfunction

    ent_t             slot_r     [N];
    ent_t             woke_ext_s [N+1];
    ent_t             slot_nxt_s [N];
    ent_t             dis_ent_s;
    logic [CNT_W-1:0] occ_r;
    logic [CNT_W-1:0] occ_nxt_s;
    logic [CNT_W-1:0] wr_idx_s;
    logic [N-1:0]     elig_s;
    logic [IDX_W-1:0] sel_s;
    logic             any_elig_s;
    logic             load_en_s;
    logic             issue_load_s;
    logic             dis_acc_s;
    logic             cdb_hit_s;
    logic             flush_s;

`ifdef TOMASULO_RS_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Tag 0 means "no producer", so a broadcast on it never wakes anything.
    assign cdb_hit_s    = cdb_vld && (cdb_tag != {TAG_W{1'b0}});
    assign load_en_s    = !iss_vld_r || iss_rdy;
    assign issue_load_s = load_en_s && any_elig_s;
    assign dis_acc_s    = dis_vld_r && (occ_r != CNT_W'(N)) && !flush_s;
    assign wr_idx_s     = occ_r - CNT_W'(issue_load_s);
    assign occ_nxt_s    = occ_r + CNT_W'(dis_acc_s) - CNT_W'(issue_load_s);

    // Eligibility and oldest-first selection from registered slot state only.
    always_comb begin
        sel_s = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            elig_s[i] = slot_r[i].vld && slot_r[i].s0.rdy && slot_r[i].s1.rdy;
        end
        for (int i = N - 1; i >= 0; i--) begin
            sel_s = elig_s[i] ? IDX_W'(i) : sel_s;
        end
        any_elig_s = |elig_s;
    end

    // Incoming dispatch, with same-cycle CDB bypass on its missing operands.
    always_comb begin
        dis_ent_s     = '0;
        dis_ent_s.vld = 1'b1;
        dis_ent_s.op  = dis_op;
        dis_ent_s.tag = dis_tag;
        dis_ent_s.s0  = snoop_src(src_t'{rdy: dis_s0_rdy, tag: dis_s0_tag, data: dis_s0_data},
                                  cdb_hit_s, cdb_tag, cdb_data);
        dis_ent_s.s1  = snoop_src(src_t'{rdy: dis_s1_rdy, tag: dis_s1_tag, data: dis_s1_data},
                                  cdb_hit_s, cdb_tag, cdb_data);
    end

    // Wakeup, then collapse over the issued slot, then append the dispatch at the young end.
    always_comb begin
        woke_ext_s[N] = '0;
        for (int i = 0; i < N; i++) begin
            woke_ext_s[i]    = slot_r[i];
            woke_ext_s[i].s0 = snoop_src(slot_r[i].s0, cdb_hit_s && slot_r[i].vld, cdb_tag, cdb_data);
            woke_ext_s[i].s1 = snoop_src(slot_r[i].s1, cdb_hit_s && slot_r[i].vld, cdb_tag, cdb_data);
        end
        for (int i = 0; i < N; i++) begin
            if (dis_acc_s && wr_idx_s == CNT_W'(i)) begin
                slot_nxt_s[i] = dis_ent_s;
            end else if (issue_load_s && IDX_W'(i) >= sel_s) begin
                slot_nxt_s[i] = woke_ext_s[i+1];
            end else begin
                slot_nxt_s[i] = woke_ext_s[i];
            end
        end
    end

    // Slot storage, occupancy and the registered backpressure flag.
    always_ff @(posedge clk) begin
        if (rst || flush_s) begin
            for (int i = 0; i < N; i++) begin
                slot_r[i] <= '0;
            end
            occ_r  <= {CNT_W{1'b0}};
            full_r <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                slot_r[i] <= slot_nxt_s[i];
            end
            occ_r  <= occ_nxt_s;
            full_r <= (occ_nxt_s >= CNT_W'(N - 1));
        end
    end

    // Issue register: loads the selected slot when empty or being consumed, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_vld_r <= 1'b0;
            iss_op    <= {OP_W{1'b0}};
            iss_tag   <= {TAG_W{1'b0}};
            iss_a     <= {W{1'b0}};
            iss_b     <= {W{1'b0}};
        end else if (flush_s) begin
            iss_vld_r <= 1'b0;
        end else if (issue_load_s) begin
            iss_vld_r <= 1'b1;
            iss_op    <= slot_r[sel_s].op;
            iss_tag   <= slot_r[sel_s].tag;
            iss_a     <= slot_r[sel_s].s0.data;
            iss_b     <= slot_r[sel_s].s1.data;
        end else if (load_en_s) begin
            iss_vld_r <= 1'b0;
        end else begin
            iss_vld_r <= iss_vld_r;
        end
    end

    tomasulo_rs_chk #(.N(N), .CNT_W(CNT_W)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .dis_vld_r (dis_vld_r),
        .occ       (occ_r)
    );

endmodule
